// File: rtl/pipe_hold_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared constants and helpers for the pipeline stall/flush controller.
//   FLUSH_*  : named flush depths for flush_lvl (leading stages cleared)
//   clog2    : ceiling log2, used to size pointers and counters
package pipe_ctrl_pkg;

  localparam int FLUSH_NONE = 0;  // no flush this cycle
  localparam int FLUSH_ID   = 1;  // clear fetch/decode register
  localparam int FLUSH_EX   = 2;  // clear up to execute
  localparam int FLUSH_MEM  = 3;  // clear up to memory

  // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// pipe_hold_ctrl_if
// Bundles the fetch/data bus handshake, hazard/redirect requests and the
// per-stage pipeline controls seen by pipe_hold_ctrl.
//   master : bus/pipeline side (drives requests, consumes enables/flushes)
//   slave  : the controller itself
interface pipe_hold_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int LVL_W  = 2
);

  logic              i_bus_en;
  logic              i_bus_ready;
  logic              d_bus_en;
  logic              d_bus_ready;
  logic              local_stop;
  logic [LVL_W-1:0]  flush_lvl;
  logic [XLEN-1:0]   i_data_in;
  logic [XLEN-1:0]   i_data_out;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_flush_n;
  logic              pc_en;
  logic              hold_ovf;
  logic              bus_timeout;
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_events;

  modport master (
    output i_bus_en, i_bus_ready, d_bus_en, d_bus_ready, local_stop,
           flush_lvl, i_data_in,
    input  i_data_out, stage_en, stage_flush_n, pc_en, hold_ovf,
           bus_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  i_bus_en, i_bus_ready, d_bus_en, d_bus_ready, local_stop,
           flush_lvl, i_data_in,
    output i_data_out, stage_en, stage_flush_n, pc_en, hold_ovf,
           bus_timeout, stall_cycles, flush_events
  );

endinterface

// File: rtl/pipe_hold_ctrl_hold_fifo.sv
// hold_fifo
// Small circular buffer that keeps fetched words arriving while the front
// end is held.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and word (dropped when full without a pop)
//   pop        : remove head
//   clr        : discard all entries at the next edge (wins over push/pop)
//   head       : oldest word
//   empty/full : occupancy flags
//   ovf        : sticky, a push was dropped; cleared only by reset
module hold_fifo
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int HOLD_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clr,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] head,
  output logic            empty,
  output logic            full,
  output logic            ovf
);

  localparam int PTR_W = (clog2(HOLD_DEPTH) < 1) ? 1 : clog2(HOLD_DEPTH);
  localparam int CNT_W = clog2(HOLD_DEPTH + 1);

  logic [XLEN-1:0]  mem_r [HOLD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;
  logic             empty_s;
  logic             full_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             drop_s;

  // Pointer advance with explicit wrap so any depth works, not just 2^n.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(HOLD_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Occupancy flags and accepted-operation qualifiers.
  always_comb begin
    empty_s = (cnt_r == CNT_W'(0));
    full_s  = (cnt_r == CNT_W'(HOLD_DEPTH));
    // A full buffer still accepts a push when a pop frees a slot.
    wr_ok_s = push & (~full_s | pop) & ~clr;
    rd_ok_s = pop & ~empty_s & ~clr;
    drop_s  = push & full_s & ~pop & ~clr;
  end

  // Storage array; contents need no reset because cnt_r gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy count and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      ovf_r    <= 1'b0;
    end else begin
      ovf_r <= ovf_r | drop_s;
      if (clr) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        cnt_r    <= '0;
      end else begin
        if (wr_ok_s) begin
          wr_ptr_r <= ptr_inc(wr_ptr_r);
        end
        if (rd_ok_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
        case ({wr_ok_s, rd_ok_s})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_r;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl
// Stall/flush controller for an N-stage integer pipeline. Derives per-stage
// register enables and active-low flushes from bus wait, load-use hold and
// redirect requests, buffers fetched words during a front-end hold, and
// watches for a bus that never answers.
//   clk, cpu_rst : clock, asynchronous active-low reset
//   bus (slave)  : fetch/data handshake, local_stop, flush_lvl, i_data_in in;
//                  i_data_out, stage_en, stage_flush_n, pc_en, hold_ovf,
//                  bus_timeout, stall_cycles, flush_events out
// Build option: define PIPE_PERF_CNT_EN to build the stall_cycles and
// flush_events counters; otherwise both read as zero.
module pipe_hold_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STAGES     = 4,
  parameter int FRONT      = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int TIMEOUT    = 255,
  parameter int LVL_W      = 2
) (
  input logic             clk,
  input logic             cpu_rst,
  pipe_hold_ctrl_if.slave bus
);

  localparam int WCNT_W = clog2(TIMEOUT + 1);

  logic              i_wait_s;
  logic              d_wait_s;
  logic              bwait_s;
  logic              front_en_s;
  logic              flush_now_s;
  logic              squash_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic              fifo_full_unused_s;
  logic              fifo_ovf_s;
  logic [XLEN-1:0]   fifo_head_s;
  int                lvl_raw_s;
  int                lvl_s;
  logic [STAGES-1:0] en_run_s;
  logic [STAGES-1:0] flush_n_run_s;
  logic [STAGES-1:0] stage_en_s;
  logic [STAGES-1:0] stage_flush_n_s;
  logic [XLEN-1:0]   data_out_s;
  logic              squash_d_r;
  logic [WCNT_W-1:0] wcnt_r;
  logic              bus_timeout_r;

  // Wait terms, front-end enable and hold-buffer requests.
  always_comb begin
    i_wait_s    = bus.i_bus_en & ~bus.i_bus_ready;
    d_wait_s    = bus.d_bus_en & ~bus.d_bus_ready;
    bwait_s     = i_wait_s | d_wait_s;
    front_en_s  = ~bwait_s & ~bus.local_stop;
    flush_now_s = (bus.flush_lvl != LVL_W'(FLUSH_NONE));
    squash_s    = flush_now_s | squash_d_r;
    // A redirect makes any word fetched this cycle stale, so it is not kept.
    push_s      = bus.i_bus_en & bus.i_bus_ready & ~front_en_s & ~flush_now_s;
    pop_s       = front_en_s & ~fifo_empty_s;
  end

  // Per-stage enables and flushes; reset forces every register to clear.
  always_comb begin
    lvl_raw_s = int'(bus.flush_lvl);
    // The last stage always retires, so deeper requests saturate short of it.
    lvl_s     = (lvl_raw_s > STAGES - 1) ? STAGES - 1 : lvl_raw_s;
    en_run_s      = '0;
    flush_n_run_s = '1;
    for (int k = 0; k < STAGES; k++) begin
      en_run_s[k]      = (k < FRONT) ? front_en_s : ~bwait_s;
      flush_n_run_s[k] = (k < lvl_s) ? 1'b0 : 1'b1;
    end
    if (!cpu_rst) begin
      stage_en_s      = '1;
      stage_flush_n_s = '0;
    end else begin
      stage_en_s      = en_run_s;
      stage_flush_n_s = flush_n_run_s;
    end
  end

  // Word presented to the stage-0 register.
  always_comb begin
    if (!cpu_rst) begin
      data_out_s = bus.i_data_in;
    end else if (squash_s) begin
      // Zero word decodes as a harmless bubble after a redirect.
      data_out_s = '0;
    end else if (!fifo_empty_s) begin
      data_out_s = fifo_head_s;
    end else begin
      data_out_s = bus.i_data_in;
    end
  end

  // Words fetched while the front end is held wait here.
  hold_fifo #(
    .XLEN       (XLEN),
    .HOLD_DEPTH (HOLD_DEPTH)
  ) u_hold_fifo (
    .clk   (clk),
    .rst_n (cpu_rst),
    .push  (push_s),
    .pop   (pop_s),
    .clr   (flush_now_s),
    .din   (bus.i_data_in),
    .head  (fifo_head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_unused_s),
    .ovf   (fifo_ovf_s)
  );

  // Squash history and bus-wait watchdog.
  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      squash_d_r    <= 1'b0;
      wcnt_r        <= '0;
      bus_timeout_r <= 1'b0;
    end else begin
      squash_d_r <= flush_now_s;
      if (bwait_s) begin
        // Saturate at TIMEOUT so a persisting wait fires only once.
        if (wcnt_r != WCNT_W'(TIMEOUT)) begin
          wcnt_r <= wcnt_r + WCNT_W'(1);
        end else begin
          wcnt_r <= wcnt_r;
        end
        bus_timeout_r <= (wcnt_r == WCNT_W'(TIMEOUT - 1));
      end else begin
        wcnt_r        <= '0;
        bus_timeout_r <= 1'b0;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_events_r;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      stall_cycles_r <= 32'd0;
      flush_events_r <= 32'd0;
    end else begin
      if (!front_en_s) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (flush_now_s) begin
        flush_events_r <= flush_events_r + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_r;
  assign bus.flush_events = flush_events_r;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_events = 32'd0;
`endif

  assign bus.i_data_out    = data_out_s;
  assign bus.stage_en      = stage_en_s;
  assign bus.stage_flush_n = stage_flush_n_s;
  assign bus.pc_en         = ~cpu_rst | front_en_s;
  assign bus.hold_ovf      = fifo_ovf_s;
  assign bus.bus_timeout   = bus_timeout_r;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
module tb_pipe_hold_ctrl;

  localparam int XLEN       = 32;
  localparam int STAGES     = 4;
  localparam int FRONT      = 2;
  localparam int HOLD_DEPTH = 2;
  localparam int TIMEOUT    = 8;
  localparam int LVL_W      = 2;
  localparam int NV         = 24;

  typedef struct {
    logic        irdy;
    logic        den;
    logic        drdy;
    logic        stop;
    logic [1:0]  lvl;
    logic [31:0] din;
    logic [3:0]  en;
    logic [3:0]  fn;
    logic        pc;
    logic [31:0] dout;
    logic        ovf;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  en;
    logic [3:0]  fn;
    logic        pc;
    logic [31:0] dout;
    logic        ovf;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic cpu_rst;
  int   passed = 0;
  int   total  = 0;
  vec_t vecs [NV];
  exp_t sb_q [$];

  always #5 clk = ~clk;

  pipe_hold_ctrl_if #(.XLEN(XLEN), .STAGES(STAGES), .LVL_W(LVL_W)) bus ();

  pipe_hold_ctrl #(
    .XLEN(XLEN), .STAGES(STAGES), .FRONT(FRONT), .HOLD_DEPTH(HOLD_DEPTH),
    .TIMEOUT(TIMEOUT), .LVL_W(LVL_W)
  ) dut (
    .clk     (clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic irdy, input logic den, input logic drdy,
                              input logic stop, input logic [1:0] lvl, input logic [31:0] din,
                              input logic [3:0] en, input logic [3:0] fn, input logic pc,
                              input logic [31:0] dout, input logic ovf);
    vec_t v;
    v.irdy = irdy; v.den = den; v.drdy = drdy; v.stop = stop; v.lvl = lvl; v.din = din;
    v.en = en; v.fn = fn; v.pc = pc; v.dout = dout; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e;
    int   pulses;
    int   first_at;

    //            irdy  den   drdy  stop  lvl    din            en       fn       pc    dout           ovf
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h11111111, 4'b1111, 4'b1111, 1'b1, 32'h11111111, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'hDEAD0001, 4'b0000, 4'b1111, 1'b0, 32'hDEAD0001, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'hDEAD0002, 4'b0000, 4'b1111, 1'b0, 32'hDEAD0002, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'hDEAD0003, 4'b0000, 4'b1111, 1'b0, 32'hDEAD0003, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h22222222, 4'b1111, 4'b1111, 1'b1, 32'h22222222, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h66666666, 4'b0000, 4'b1111, 1'b0, 32'h66666666, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h77777777, 4'b1111, 4'b1111, 1'b1, 32'h66666666, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h88888888, 4'b1111, 4'b1111, 1'b1, 32'h88888888, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h00A00093, 4'b1100, 4'b1111, 1'b0, 32'h00A00093, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00100113, 4'b1111, 4'b1111, 1'b1, 32'h00A00093, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00100113, 4'b1111, 4'b1111, 1'b1, 32'h00100113, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h33333333, 4'b1100, 4'b1100, 1'b0, 32'h00000000, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h44444444, 4'b1111, 4'b1111, 1'b1, 32'h00000000, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h55555555, 4'b1111, 4'b1111, 1'b1, 32'h55555555, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000A001, 4'b1100, 4'b1111, 1'b0, 32'h0000A001, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000A002, 4'b1100, 4'b1111, 1'b0, 32'h0000A001, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000A003, 4'b1100, 4'b1111, 1'b0, 32'h0000A001, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000A004, 4'b1100, 4'b1111, 1'b0, 32'h0000A001, 1'b1);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000B001, 4'b1111, 4'b1111, 1'b1, 32'h0000A001, 1'b1);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000B002, 4'b1111, 4'b1111, 1'b1, 32'h0000A002, 1'b1);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000B003, 4'b1111, 4'b1111, 1'b1, 32'h0000B003, 1'b1);
    vecs[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0000C001, 4'b1111, 4'b1000, 1'b1, 32'h00000000, 1'b1);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000C002, 4'b1111, 4'b1111, 1'b1, 32'h00000000, 1'b1);
    vecs[23] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000C003, 4'b1111, 4'b1111, 1'b1, 32'h0000C003, 1'b1);

    // Reset state
    cpu_rst = 1'b0;
    bus.i_bus_en = 1'b1; bus.i_bus_ready = 1'b1; bus.d_bus_en = 1'b0; bus.d_bus_ready = 1'b0;
    bus.local_stop = 1'b0; bus.flush_lvl = 2'd0; bus.i_data_in = 32'h12345678;
    #12;
    check("rst_stage_en", bus.stage_en, 32'h0000000F);
    check("rst_flush_n", bus.stage_flush_n, 32'h00000000);
    check("rst_pc_en", bus.pc_en, 32'd1);
    check("rst_dout", bus.i_data_out, 32'h12345678);
    check("rst_ovf", bus.hold_ovf, 32'd0);
    check("rst_timeout", bus.bus_timeout, 32'd0);
    check("rst_stall_cnt", bus.stall_cycles, 32'd0);
    check("rst_flush_cnt", bus.flush_events, 32'd0);
    bus.flush_lvl = 2'd2;
    #1;
    check("rst_dout_flush", bus.i_data_out, 32'h12345678);
    check("rst_flush_n_lvl", bus.stage_flush_n, 32'h00000000);
    bus.flush_lvl = 2'd0;
    @(negedge clk);
    cpu_rst = 1'b1;

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      bus.i_bus_en = 1'b1; bus.i_bus_ready = vecs[i].irdy;
      bus.d_bus_en = vecs[i].den; bus.d_bus_ready = vecs[i].drdy;
      bus.local_stop = vecs[i].stop; bus.flush_lvl = vecs[i].lvl; bus.i_data_in = vecs[i].din;
      e.idx = i; e.en = vecs[i].en; e.fn = vecs[i].fn; e.pc = vecs[i].pc;
      e.dout = vecs[i].dout; e.ovf = vecs[i].ovf; e.to = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_stage_en", e.idx), bus.stage_en, {28'd0, e.en});
        check($sformatf("v%0d_flush_n", e.idx), bus.stage_flush_n, {28'd0, e.fn});
        check($sformatf("v%0d_pc_en", e.idx), bus.pc_en, {31'd0, e.pc});
        check($sformatf("v%0d_dout", e.idx), bus.i_data_out, e.dout);
        check($sformatf("v%0d_ovf", e.idx), bus.hold_ovf, {31'd0, e.ovf});
        check($sformatf("v%0d_timeout", e.idx), bus.bus_timeout, {31'd0, e.to});
      end
    end
    check("sb_drained", sb_q.size(), 32'd0);

    // Watchdog: 20 cycles of data-bus wait, one pulse after TIMEOUT wait edges
    @(posedge clk);
    #1;
    bus.i_bus_en = 1'b0; bus.d_bus_en = 1'b1; bus.d_bus_ready = 1'b0;
    bus.local_stop = 1'b0; bus.flush_lvl = 2'd0;
    pulses = 0; first_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.bus_timeout === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = c;
      end
    end
    check("wd_pulses", pulses, 32'd1);
    check("wd_first_at", first_at, TIMEOUT + 1);
    @(posedge clk);
    #1;
    bus.d_bus_ready = 1'b1;
    @(negedge clk);
    check("wd_drop_timeout", bus.bus_timeout, 32'd0);
    check("wd_drop_stage_en", bus.stage_en, 32'h0000000F);
    @(posedge clk);
    #1;
    bus.d_bus_ready = 1'b0;
    pulses = 0; first_at = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.bus_timeout === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = c;
      end
    end
    check("wd2_pulses", pulses, 32'd1);
    check("wd2_first_at", first_at, TIMEOUT + 1);

    // Reset mid-hold with one word buffered
    @(posedge clk);
    #1;
    bus.d_bus_en = 1'b0; bus.i_bus_en = 1'b1; bus.i_bus_ready = 1'b1;
    bus.local_stop = 1'b1; bus.i_data_in = 32'hFACE0001;
    @(posedge clk);
    #1;
    bus.i_data_in = 32'hFACE0002;
    #1;
    check("mh_buffered", bus.i_data_out, 32'hFACE0001);
    check("mh_stage_en", bus.stage_en, 32'h0000000C);
    #1;
    cpu_rst = 1'b0;
    #1;
    check("mh_rst_stage_en", bus.stage_en, 32'h0000000F);
    check("mh_rst_flush_n", bus.stage_flush_n, 32'h00000000);
    check("mh_rst_pc_en", bus.pc_en, 32'd1);
    check("mh_rst_dout", bus.i_data_out, 32'hFACE0002);
    check("mh_rst_ovf", bus.hold_ovf, 32'd0);
    check("mh_rst_stall", bus.stall_cycles, 32'd0);
    @(negedge clk);
    bus.local_stop = 1'b0; bus.i_data_in = 32'hFACE0003;
    cpu_rst = 1'b1;
    #1;
    check("mh_post_dout", bus.i_data_out, 32'hFACE0003);
    check("mh_post_flush_n", bus.stage_flush_n, 32'h0000000F);
    @(posedge clk);
    #1;
    check("mh_post2_dout", bus.i_data_out, 32'hFACE0003);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
